// File: rtl/dmem_dual_issue.sv
`default_nettype none
// ============================================================================
// Module   : dmem_dual_issue
// Brief    : Dual-port byte-enabled data memory for the dual-issue MEM stage,
//            with a post-reset zero-clear sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_dual_issue #(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 64,
  parameter int READ_LATENCY = 0,
  parameter int INIT_CLEAR   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_ready,
  input  logic                  MemWrite_M,
  input  logic [DATA_W/8-1:0]   ByteEn_M,
  input  logic [31:0]           ALUOut_M,
  input  logic [DATA_W-1:0]     WriteData_M,
  output logic [DATA_W-1:0]     ReadData_M,
  output logic                  MemFault_M,
  input  logic                  MemWrite_M2,
  input  logic [DATA_W/8-1:0]   ByteEn_M2,
  input  logic [31:0]           ALUOut_M2,
  input  logic [DATA_W-1:0]     WriteData_M2,
  output logic [DATA_W-1:0]     ReadData_M2,
  output logic                  MemFault_M2
);

  localparam int                c_BE_W   = DATA_W / 8;
  localparam int                c_OFF    = $clog2(c_BE_W);
  localparam int                c_IDX_W  = $clog2(DEPTH);
  localparam logic [31:0]       c_DEPTH  = 32'(DEPTH);
  localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(DEPTH - 1);

  typedef enum logic [0:0] {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_IDX_W-1:0]   r_clear_ptr;
  logic                 r_ready;
  logic                 w_clear_we;
  logic [DATA_W-1:0]    r_mem [DEPTH];

  logic                 w_run;
  logic [31:0]          w_word0, w_word1;
  logic [c_IDX_W-1:0]   w_idx0, w_idx1;
  logic                 w_oor0, w_oor1;
  logic                 w_we0, w_we1;
  logic [DATA_W-1:0]    w_old0, w_old1;

  assign w_run   = (r_state == S_RUN);
  assign w_word0 = ALUOut_M >> c_OFF;
  assign w_word1 = ALUOut_M2 >> c_OFF;
  assign w_idx0  = w_word0[c_IDX_W-1:0];
  assign w_idx1  = w_word1[c_IDX_W-1:0];
  assign w_oor0  = (w_word0 >= c_DEPTH);
  assign w_oor1  = (w_word1 >= c_DEPTH);
  assign w_we0   = w_run && MemWrite_M  && !w_oor0;
  assign w_we1   = w_run && MemWrite_M2 && !w_oor1;
  assign w_old0  = r_mem[w_idx0];
  assign w_old1  = r_mem[w_idx1];
  assign mem_ready = r_ready;

  // Sequencer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_CLEAR;
      r_clear_ptr <= '0;
      r_ready     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_CLEAR) begin
        r_clear_ptr <= r_clear_ptr + c_IDX_W'(1);
        if (w_state_nxt == S_RUN) r_ready <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clear_we  = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clear_we = (INIT_CLEAR != 0);
        if (INIT_CLEAR == 0 || r_clear_ptr == c_LAST) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Port 1 lanes are written after port 0 so the younger store wins on overlap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_clear_we) r_mem[r_clear_ptr] <= '0;
      if (w_we0) begin
        for (int i = 0; i < c_BE_W; i++)
          if (ByteEn_M[i]) r_mem[w_idx0][8*i +: 8] <= WriteData_M[8*i +: 8];
      end
      if (w_we1) begin
        for (int i = 0; i < c_BE_W; i++)
          if (ByteEn_M2[i]) r_mem[w_idx1][8*i +: 8] <= WriteData_M2[8*i +: 8];
      end
    end
  end

  function automatic logic [DATA_W-1:0] f_merge(
    input logic [DATA_W-1:0] old,
    input logic              hit0,
    input logic [c_BE_W-1:0] be0,
    input logic [DATA_W-1:0] wd0,
    input logic              hit1,
    input logic [c_BE_W-1:0] be1,
    input logic [DATA_W-1:0] wd1
  );
    logic [DATA_W-1:0] v;
    v = old;
    for (int i = 0; i < c_BE_W; i++) begin
      if (hit0 && be0[i]) v[8*i +: 8] = wd0[8*i +: 8];
      if (hit1 && be1[i]) v[8*i +: 8] = wd1[8*i +: 8];
    end
    return v;
  endfunction

  generate
    if (READ_LATENCY == 0) begin : g_rd_comb
      assign ReadData_M  = (w_run && !w_oor0) ? w_old0 : '0;
      assign ReadData_M2 = (w_run && !w_oor1) ? w_old1 : '0;
      assign MemFault_M  = w_run && w_oor0;
      assign MemFault_M2 = w_run && w_oor1;
    end else begin : g_rd_reg
      logic [DATA_W-1:0] r_rd0, r_rd1;
      logic              r_flt0, r_flt1;
      logic [DATA_W-1:0] w_fwd0, w_fwd1;

      // Write-first: the registered word already includes this edge's stores.
      assign w_fwd0 = f_merge(w_old0, w_we0, ByteEn_M, WriteData_M,
                              w_we1 && (w_idx1 == w_idx0), ByteEn_M2, WriteData_M2);
      assign w_fwd1 = f_merge(w_old1, w_we0 && (w_idx0 == w_idx1), ByteEn_M, WriteData_M,
                              w_we1, ByteEn_M2, WriteData_M2);

      always_ff @(posedge clk) begin
        if (reset || !w_run) begin
          r_rd0  <= '0;
          r_rd1  <= '0;
          r_flt0 <= 1'b0;
          r_flt1 <= 1'b0;
        end else begin
          r_rd0  <= w_oor0 ? '0 : w_fwd0;
          r_rd1  <= w_oor1 ? '0 : w_fwd1;
          r_flt0 <= w_oor0;
          r_flt1 <= w_oor1;
        end
      end

      assign ReadData_M  = r_rd0;
      assign ReadData_M2 = r_rd1;
      assign MemFault_M  = r_flt0;
      assign MemFault_M2 = r_flt1;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dmem_dual_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_dual_issue
// Brief    : Directed bench driving a combinational-read and a registered-read
//            instance with shared stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_dual_issue;

  logic        clk;
  logic        reset;
  logic        mw0, mw1;
  logic [3:0]  be0, be1;
  logic [31:0] a0, a1, wd0, wd1;
  logic [31:0] rd0_c, rd1_c, rd0_r, rd1_r;
  logic        f0_c, f1_c, f0_r, f1_r;
  logic        rdy_c, rdy_r;
  int          n_chk;
  int          n_fail;
  logic        bad;

  dmem_dual_issue #(.DATA_W(32), .DEPTH(64), .READ_LATENCY(0), .INIT_CLEAR(1)) u_dut_c (
    .clk(clk), .reset(reset), .mem_ready(rdy_c),
    .MemWrite_M(mw0), .ByteEn_M(be0), .ALUOut_M(a0), .WriteData_M(wd0),
    .ReadData_M(rd0_c), .MemFault_M(f0_c),
    .MemWrite_M2(mw1), .ByteEn_M2(be1), .ALUOut_M2(a1), .WriteData_M2(wd1),
    .ReadData_M2(rd1_c), .MemFault_M2(f1_c)
  );

  dmem_dual_issue #(.DATA_W(32), .DEPTH(64), .READ_LATENCY(1), .INIT_CLEAR(1)) u_dut_r (
    .clk(clk), .reset(reset), .mem_ready(rdy_r),
    .MemWrite_M(mw0), .ByteEn_M(be0), .ALUOut_M(a0), .WriteData_M(wd0),
    .ReadData_M(rd0_r), .MemFault_M(f0_r),
    .MemWrite_M2(mw1), .ByteEn_M2(be1), .ALUOut_M2(a1), .WriteData_M2(wd1),
    .ReadData_M2(rd1_r), .MemFault_M2(f1_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic m0, input logic [3:0] b0, input logic [31:0] ad0,
                     input logic [31:0] d0, input logic m1, input logic [3:0] b1,
                     input logic [31:0] ad1, input logic [31:0] d1);
    mw0 = m0; be0 = b0; a0 = ad0; wd0 = d0;
    mw1 = m1; be1 = b1; a1 = ad1; wd1 = d1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    drv(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
    repeat (3) tick();
    chk("rst_ready_c", 32'(rdy_c), 32'd0);
    chk("rst_ready_r", 32'(rdy_r), 32'd0);
    chk("rst_rd_r", rd0_r, 32'h0);
    chk("rst_flt_r", 32'(f0_r), 32'd0);

    // Clear sequence: 63 edges not ready, ready after the 64th
    a0    = 32'h40;
    reset = 1'b0;
    bad   = 1'b0;
    for (int k = 0; k < 63; k++) begin
      tick();
      if (rdy_c !== 1'b0 || rdy_r !== 1'b0 || rd0_c !== 32'h0 || f0_c !== 1'b0 ||
          rd0_r !== 32'h0 || f0_r !== 1'b0) bad = 1'b1;
    end
    chk("clear_busy", 32'(bad), 32'd0);
    tick();
    chk("clear_ready_c", 32'(rdy_c), 32'd1);
    chk("clear_ready_r", 32'(rdy_r), 32'd1);
    chk("clear_rd40_c", rd0_c, 32'h0);
    tick();
    chk("clear_rd40_r", rd0_r, 32'h0);

    // Full-word write
    drv(1, 4'hF, 32'h10, 32'hDEADBEEF, 0, 4'h0, 32'h10, 32'h0);
    #1 chk("wr_old_c", rd0_c, 32'h0);
    tick();
    chk("wr_fwd_r", rd0_r, 32'hDEADBEEF);
    drv(0, 4'h0, 32'h10, 32'h0, 0, 4'h0, 32'h10, 32'h0);
    #1 chk("wr_new_c0", rd0_c, 32'hDEADBEEF);
    chk("wr_new_c1", rd1_c, 32'hDEADBEEF);

    // Store with no byte lanes leaves the word alone
    drv(1, 4'h0, 32'h10, 32'h0, 0, 4'h0, 32'h10, 32'h0);
    tick();
    drv(0, 4'h0, 32'h10, 32'h0, 0, 4'h0, 32'h10, 32'h0);
    #1 chk("be0_noop_c", rd0_c, 32'hDEADBEEF);

    // Same-word merge: lane0 p0, lanes1-2 p1 (lane1 overlap -> p1), lane3 untouched
    drv(1, 4'h3, 32'h20, 32'h11223344, 1, 4'h6, 32'h20, 32'hAABBCCDD);
    #1 chk("merge_old_c", rd0_c, 32'h0);
    tick();
    chk("merge_fwd_r0", rd0_r, 32'h00BBCC44);
    chk("merge_fwd_r1", rd1_r, 32'h00BBCC44);
    drv(0, 4'h0, 32'h20, 32'h0, 0, 4'h0, 32'h20, 32'h0);
    #1 chk("merge_c", rd0_c, 32'h00BBCC44);

    // Cross-port write-first forwarding
    drv(1, 4'hF, 32'h08, 32'h12345678, 0, 4'h0, 32'h0, 32'h0);
    tick();
    drv(0, 4'h0, 32'h08, 32'h0, 1, 4'h8, 32'h08, 32'hFFFFFFFF);
    #1 chk("fwd_old_c", rd0_c, 32'h12345678);
    tick();
    chk("fwd_r", rd0_r, 32'hFF345678);
    drv(0, 4'h0, 32'h08, 32'h0, 0, 4'h0, 32'h08, 32'h0);
    #1 chk("fwd_c", rd0_c, 32'hFF345678);

    // Out-of-range write on port 0 alongside an in-range write on port 1
    drv(1, 4'hF, 32'h100, 32'hCAFEF00D, 1, 4'hF, 32'h04, 32'h5);
    #1 chk("oor_flt0_c", 32'(f0_c), 32'd1);
    chk("oor_rd0_c", rd0_c, 32'h0);
    chk("oor_flt1_c", 32'(f1_c), 32'd0);
    tick();
    chk("oor_flt0_r", 32'(f0_r), 32'd1);
    chk("oor_rd0_r", rd0_r, 32'h0);
    drv(0, 4'h0, 32'h00, 32'h0, 0, 4'h0, 32'h04, 32'h0);
    #1 chk("oor_alias0_c", rd0_c, 32'h0);
    chk("oor_word4_c", rd1_c, 32'h5);
    chk("oor_noflt_c", 32'(f0_c), 32'd0);
    a0 = 32'h10;
    #1 chk("oor_word10_c", rd0_c, 32'hDEADBEEF);

    // Reset in the middle of the clear sequence restarts it
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (30) tick();
    reset = 1'b1;
    tick();
    chk("midrst_ready", 32'(rdy_c), 32'd0);
    reset = 1'b0;
    bad   = 1'b0;
    for (int k = 0; k < 63; k++) begin
      tick();
      if (rdy_c !== 1'b0 || rdy_r !== 1'b0) bad = 1'b1;
    end
    chk("midrst_busy", 32'(bad), 32'd0);
    tick();
    chk("midrst_ready_c", 32'(rdy_c), 32'd1);
    chk("midrst_ready_r", 32'(rdy_r), 32'd1);
    chk("midrst_rd10_c", rd0_c, 32'h0);
    tick();
    chk("midrst_rd10_r", rd0_r, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
